// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 receive path.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Entry layout: {ext, brk, code[7:0]}
  localparam int PS2_ENTRY_W  = 10;
  localparam int PS2_CODE_LSB = 0;
  localparam int PS2_CODE_MSB = 7;
  localparam int PS2_BRK_BIT  = 8;
  localparam int PS2_EXT_BIT  = 9;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk_50,
  input  logic                       areset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH+1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_push;
  logic                w_pop;

  assign full    = (r_count == c_CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_pop   = rd_en & ~empty;
  // A write into a full FIFO still lands when the head leaves in the same cycle.
  assign w_push  = wr_en & (~full | w_pop);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clk_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_50 or negedge areset_n) begin
    if (!areset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver with glitch filter, error pulses,
//            optional E0/F0 prefix folding and a FWFT output FIFO.
// Revision : 1.0
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 5,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                            clk_50,
  input  logic                            areset_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_dat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_code,
  output logic                            out_ext,
  output logic                            out_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES+1);

  logic                    r_clk_meta, r_clk_sync;
  logic                    r_dat_meta, r_dat_sync;
  logic [2*FILTER_LEN-1:0] r_filt;
  logic                    w_strobe;

  ps2_state_e              r_state, w_state_nxt;
  logic [2:0]              r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]              r_shift, w_shift_nxt;
  logic                    r_par_bit, w_par_nxt;
  logic [c_TMO_W-1:0]      r_tmo_cnt, w_tmo_nxt;
  logic                    w_byte_ok, w_par_bad, w_stop_bad, w_tmo_hit;

  logic                    r_byte_vld;
  logic [7:0]              r_byte;
  logic                    r_parity_err, r_frame_err;

  logic                    w_push, w_pop;
  logic [PS2_ENTRY_W-1:0]  w_entry, w_head;
  logic                    w_fifo_full, w_fifo_empty;

  // Older half of the window all high and newer half all low marks one clean fall.
  assign w_strobe = (&r_filt[2*FILTER_LEN-1:FILTER_LEN]) & ~(|r_filt[FILTER_LEN-1:0]);

  always_ff @(posedge clk_50 or negedge areset_n) begin
    if (!areset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_filt     <= '1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_dat;
      r_dat_sync <= r_dat_meta;
      r_filt     <= {r_filt[2*FILTER_LEN-2:0], r_clk_sync};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par_bit;
    w_tmo_nxt     = '0;
    w_byte_ok     = 1'b0;
    w_par_bad     = 1'b0;
    w_stop_bad    = 1'b0;
    w_tmo_hit     = 1'b0;
    if (r_state != IDLE) begin
      w_tmo_nxt = r_tmo_cnt + 1'b1;
    end
    // Counter holds cycles elapsed since the last strobe of the frame.
    if (w_strobe) begin
      w_tmo_nxt = c_TMO_W'(1);
      case (r_state)
        IDLE: begin
          if (!r_dat_sync) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_tmo_nxt = '0;
          end
        end
        DATA: begin
          w_shift_nxt = {r_dat_sync, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
          else                   w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
        PARITY: begin
          w_par_nxt   = r_dat_sync;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          w_tmo_nxt   = '0;
          if (!odd_parity_ok(r_shift, r_par_bit)) w_par_bad  = 1'b1;
          else if (!r_dat_sync)                   w_stop_bad = 1'b1;
          else                                    w_byte_ok  = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if ((r_state != IDLE) && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES-1))) begin
      w_tmo_hit   = 1'b1;
      w_state_nxt = IDLE;
      w_tmo_nxt   = '0;
    end
  end

  always_ff @(posedge clk_50 or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_tmo_cnt    <= '0;
      r_byte_vld   <= 1'b0;
      r_byte       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par_bit    <= w_par_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_byte_vld   <= w_byte_ok;
      r_parity_err <= w_par_bad;
      r_frame_err  <= w_stop_bad | w_tmo_hit;
      if (w_byte_ok) r_byte <= r_shift;
    end
  end

  generate
    if (DECODE_PREFIX != 0) begin : g_prefix
      logic r_ext_pend, r_brk_pend;
      logic w_is_ext, w_is_brk;

      assign w_is_ext = (r_byte == PS2_PREFIX_EXT);
      assign w_is_brk = (r_byte == PS2_PREFIX_BRK);
      assign w_push   = r_byte_vld & ~w_is_ext & ~w_is_brk;
      assign w_entry  = {r_ext_pend, r_brk_pend, r_byte};

      always_ff @(posedge clk_50 or negedge areset_n) begin
        if (!areset_n) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else if (r_parity_err || r_frame_err) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else if (r_byte_vld) begin
          if (w_is_ext) begin
            r_ext_pend <= 1'b1;
          end else if (w_is_brk) begin
            r_brk_pend <= 1'b1;
          end else begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
        end
      end
    end else begin : g_raw
      assign w_push  = r_byte_vld;
      assign w_entry = {2'b00, r_byte};
    end
  endgenerate

  assign w_pop = out_valid & out_ready;

  ps2_sync_fifo #(
    .WIDTH (PS2_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50   (clk_50),
    .areset_n (areset_n),
    .wr_en    (w_push),
    .wr_data  (w_entry),
    .rd_en    (w_pop),
    .rd_data  (w_head),
    .count    (fifo_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  assign out_valid  = ~w_fifo_empty;
  assign out_code   = w_head[PS2_CODE_MSB:PS2_CODE_LSB];
  assign out_ext    = w_head[PS2_EXT_BIT];
  assign out_break  = w_head[PS2_BRK_BIT];
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = w_push & w_fifo_full & ~w_pop;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Randomised self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int FL    = 5;
  localparam int TMO   = 5000;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;

  logic       clk_50 = 1'b0;
  logic       areset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       out_ready = 1'b1;
  logic       out_valid, out_ext, out_break;
  logic [7:0] out_code;
  logic [3:0] fifo_count;
  logic       parity_err, frame_err, overflow;
  logic       raw_valid, raw_ext, raw_break;
  logic [7:0] raw_code;
  logic [3:0] raw_count;
  logic       raw_perr, raw_ferr, raw_ovf;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .DECODE_PREFIX(1)) dut (
    .clk_50(clk_50), .areset_n(areset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_ext(out_ext),
    .out_break(out_break), .fifo_count(fifo_count), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow));

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .DECODE_PREFIX(0)) dut_raw (
    .clk_50(clk_50), .areset_n(areset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .out_valid(raw_valid), .out_ready(1'b1), .out_code(raw_code), .out_ext(raw_ext),
    .out_break(raw_break), .fifo_count(raw_count), .parity_err(raw_perr),
    .frame_err(raw_ferr), .overflow(raw_ovf));

  always #10 clk_50 = ~clk_50;

  int n_checks = 0, n_pass = 0;
  int cnt_perr = 0, cnt_ferr = 0, cnt_ovf = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int n_pop_main = 0, n_pop_raw = 0;
  int p0, r0, ov0, first_hit;
  logic [9:0]  q_main[$];
  logic [9:0]  q_raw[$];
  logic [9:0]  e_main, e_raw;
  bit          m_ext = 0, m_brk = 0;
  logic [31:0] tr_valid, tr_perr, tr_ferr, tr_ovf;
  logic [7:0]  code;
  bit          bp, bs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: one call per complete frame, in terms of frame outcome.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit can_pop);
    if (bad_par) begin
      exp_perr++; m_ext = 0; m_brk = 0;
    end else if (bad_stop) begin
      exp_ferr++; m_ext = 0; m_brk = 0;
    end else begin
      q_raw.push_back({2'b00, d});
      if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0) m_brk = 1;
      else begin
        if (q_main.size() >= DEPTH && !can_pop) exp_ovf++;
        else q_main.push_back({m_ext, m_brk, d});
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_50); #1; out_ready = v;
  endtask

  task automatic gap();
    ps2_dat = 1'b1;
    repeat (30) @(negedge clk_50);
  endtask

  // Drives nbits of an 11-bit frame; traces outputs for HALF cycles after each fall.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input bit rdy_pulse);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        repeat (5) @(negedge clk_50);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_50);
        ps2_clk = 1'b1;
        repeat (HALF-8) @(negedge clk_50);
      end else begin
        repeat (HALF) @(negedge clk_50);
      end
      ps2_clk = 1'b0;
      if (i == 10) model_frame(d, bad_par, bad_stop, out_ready | rdy_pulse);
      tr_valid = '0; tr_perr = '0; tr_ferr = '0; tr_ovf = '0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk_50);
        tr_valid[k] = out_valid;
        tr_perr[k]  = parity_err;
        tr_ferr[k]  = frame_err;
        tr_ovf[k]   = overflow;
        if (rdy_pulse && i == 10 && k == 7) begin @(posedge clk_50); #1; out_ready = 1'b1; end
        if (rdy_pulse && i == 10 && k == 8) begin @(posedge clk_50); #1; out_ready = 1'b0; end
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  always @(negedge clk_50) begin
    if (areset_n) begin
      if (parity_err) cnt_perr++;
      if (frame_err)  cnt_ferr++;
      if (overflow)   cnt_ovf++;
      if (out_valid && out_ready) begin
        n_pop_main++;
        if (q_main.size() == 0) check_val("pop_unexpected", {22'd0, out_ext, out_break, out_code}, 32'h3FF);
        else begin
          e_main = q_main.pop_front();
          check_val("pop_entry", {22'd0, out_ext, out_break, out_code}, {22'd0, e_main});
        end
      end
      if (raw_valid) begin
        n_pop_raw++;
        if (q_raw.size() == 0) check_val("raw_unexpected", {22'd0, raw_ext, raw_break, raw_code}, 32'h3FF);
        else begin
          e_raw = q_raw.pop_front();
          check_val("raw_entry", {22'd0, raw_ext, raw_break, raw_code}, {22'd0, e_raw});
        end
      end
    end
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset_n = 1'b0;
    repeat (5) @(negedge clk_50);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_code", out_code, 0);
    check_val("rst_flags", {out_ext, out_break}, 0);
    check_val("rst_count", fifo_count, 0);
    check_val("rst_pulses", {parity_err, frame_err, overflow}, 0);
    areset_n = 1'b1;
    repeat (10) @(negedge clk_50);

    // Single good frame: out_valid visible for exactly one cycle, strobe+2.
    send_frame(8'h1C, 0, 0, 11, -1, 0);
    check_val("single_valid_trace", tr_valid, 32'h200);
    gap();
    check_val("single_pops", n_pop_main, 1);

    // E0 F0 75 folds into one entry; the raw instance sees three bytes.
    p0 = n_pop_main; r0 = n_pop_raw;
    send_frame(8'hE0, 0, 0, 11, -1, 0); gap();
    send_frame(8'hF0, 0, 0, 11, -1, 0); gap();
    send_frame(8'h75, 0, 0, 11, -1, 0); gap();
    check_val("prefix_main_pops", n_pop_main - p0, 1);
    check_val("prefix_raw_pops", n_pop_raw - r0, 3);

    // Parity error wins; stop error alone gives frame_err.
    send_frame(8'h1C, 1, 0, 11, -1, 0);
    check_val("perr_trace", tr_perr, 32'h100);
    check_val("perr_no_valid", tr_valid, 0);
    gap();
    send_frame(8'h1C, 0, 1, 11, -1, 0);
    check_val("ferr_trace", tr_ferr, 32'h100);
    check_val("ferr_no_perr", tr_perr, 0);
    gap();
    send_frame(8'h1C, 1, 1, 11, -1, 0);
    check_val("both_bad_ferr", tr_ferr, 0);
    gap();

    // Short ps2_clk glitch mid-frame must not add a bit.
    p0 = n_pop_main;
    send_frame(8'hA5, 0, 0, 11, 4, 0); gap();
    check_val("glitch_pops", n_pop_main - p0, 1);

    // Clock stops after 4 data bits.
    send_frame(8'h3C, 0, 0, 5, -1, 0);
    first_hit = 0;
    for (int k = HALF + 1; k <= 2 + FL + TMO + 100; k++) begin
      @(negedge clk_50);
      if (frame_err && first_hit == 0) first_hit = k;
    end
    exp_ferr++; m_ext = 0; m_brk = 0;
    check_val("timeout_latency", first_hit, 2 + FL + TMO);
    p0 = n_pop_main;
    send_frame(8'h5A, 0, 0, 11, -1, 0); gap();
    check_val("after_timeout_pops", n_pop_main - p0, 1);

    // Fill, overflow, then push with simultaneous pop while full.
    set_ready(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'($urandom_range(1, 8'h7F)), 0, 0, 11, -1, 0); gap();
    end
    check_val("fill_count", fifo_count, DEPTH);
    ov0 = cnt_ovf;
    send_frame(8'h6B, 0, 0, 11, -1, 0);
    check_val("ovf_trace", tr_ovf, 32'h100);
    gap();
    check_val("ovf_count", fifo_count, DEPTH);
    check_val("ovf_pulses", cnt_ovf - ov0, 1);
    send_frame(8'h29, 0, 0, 11, -1, 1); gap();
    check_val("full_pushpop_count", fifo_count, DEPTH);
    check_val("full_pushpop_ovf", cnt_ovf - ov0, 1);
    set_ready(1'b1);
    gap();
    check_val("drain_count", fifo_count, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 28; n++) begin
      case ($urandom_range(0, 9))
        0:       code = 8'hE0;
        1:       code = 8'hF0;
        default: code = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 9) == 0) || (bp && $urandom_range(0, 1) == 1);
      set_ready($urandom_range(0, 3) != 0);
      send_frame(code, bp, bs, 11, -1, 0);
      gap();
    end
    set_ready(1'b1);
    gap();
    check_val("rand_perr", cnt_perr, exp_perr);
    check_val("rand_ferr", cnt_ferr, exp_ferr);
    check_val("rand_ovf", cnt_ovf, exp_ovf);
    check_val("rand_main_left", q_main.size(), 0);

    // Reset mid-DATA discards FIFO contents and pending prefix.
    set_ready(1'b0);
    send_frame(8'h11, 0, 0, 11, -1, 0); gap();
    send_frame(8'h22, 0, 0, 11, -1, 0); gap();
    send_frame(8'hE0, 0, 0, 11, -1, 0); gap();
    check_val("pre_reset_count", fifo_count, 2);
    send_frame(8'h33, 0, 0, 4, -1, 0);
    areset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_code", out_code, 0);
    check_val("mid_rst_count", fifo_count, 0);
    check_val("mid_rst_pulses", {parity_err, frame_err, overflow}, 0);
    q_main.delete(); q_raw.delete(); m_ext = 0; m_brk = 0;
    repeat (4) @(negedge clk_50);
    areset_n = 1'b1;
    set_ready(1'b1);
    repeat (10) @(negedge clk_50);
    p0 = n_pop_main;
    send_frame(8'h1C, 0, 0, 11, -1, 0); gap();
    check_val("post_reset_pops", n_pop_main - p0, 1);

    check_val("final_perr", cnt_perr, exp_perr);
    check_val("final_ferr", cnt_ferr, exp_ferr);
    check_val("final_ovf", cnt_ovf, exp_ovf);
    check_val("final_main_left", q_main.size(), 0);
    check_val("final_raw_left", q_raw.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
